// File: rtl/hsid_band_streamer.sv
// Fetches the captured pixel and every library pixel over OBI and streams them to the HSID controller (stats: HSID_STREAMER_STATS_EN).
// Latency: a response word can appear on band_data_in the cycle after mem_rvalid; status pulses are registered.
// Backpressure: reads are credit-limited to BUF_DEPTH words in flight or buffered; ready low holds band_data_in.

module hsid_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   wr_vld_i,
    input  logic [W-1:0]           wr_dat_i,
    input  logic                   rd_rdy_i,
    output logic                   rd_vld_o,
    output logic [W-1:0]           rd_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          do_wr;
    logic          do_rd;

    assign do_wr    = wr_vld_i && (cnt_q != (PW+1)'(DEPTH));
    assign do_rd    = rd_rdy_i && (cnt_q != '0);
    assign rd_vld_o = (cnt_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (PW+1)'(do_wr) - (PW+1)'(do_rd);
        end
    end
endmodule

module hsid_band_streamer #(
    parameter int WORD_WIDTH        = 32,
    parameter int HSP_BANDS_WIDTH   = 8,
    parameter int HSP_LIBRARY_WIDTH = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int BUF_DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_start,
    input  logic                         cmd_clear,
    input  logic [ADDR_WIDTH-1:0]        cmd_captured_addr,
    input  logic [ADDR_WIDTH-1:0]        cmd_library_addr,
    input  logic [HSP_BANDS_WIDTH-1:0]   cmd_hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] cmd_library_size,
    output logic                         busy,
    output logic                         job_done,
    output logic                         job_error,
    output logic                         job_cancelled,
    output logic [31:0]                  stall_cycles,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [WORD_WIDTH-1:0]        mem_rdata,
    output logic                         start,
    output logic                         clear,
    output logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    output logic [WORD_WIDTH-1:0]        band_data_in,
    output logic                         band_data_in_valid,
    input  logic                         ready,
    input  logic                         done,
    input  logic                         error,
    input  logic                         cancelled
);
    localparam int WPP_W = HSP_BANDS_WIDTH + 1;
    localparam int CNT_W = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH + 1;
    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int BYTES = WORD_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_FLUSH} state_t;

    state_t                       state_q, state_d;
    logic [HSP_BANDS_WIDTH-1:0]   bands_q, bands_d;
    logic [HSP_LIBRARY_WIDTH-1:0] size_q, size_d;
    logic [ADDR_WIDTH-1:0]        cap_q, cap_d;
    logic [ADDR_WIDTH-1:0]        lib_q, lib_d;
    logic [WPP_W-1:0]             wpp_q, wpp_d;
    logic [CNT_W-1:0]             total_q, total_d;
    logic [CNT_W-1:0]             req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]             xfer_cnt_q, xfer_cnt_d;
    logic [OCC_W-1:0]             out_q, out_d;
    logic                         cancel_q, cancel_d;
    logic                         done_p_q, done_p_d;
    logic                         err_p_q, err_p_d;
    logic                         canc_p_q, canc_p_d;
    logic                         clear_q, clear_d;

    logic [WPP_W-1:0]      wpp_calc;
    logic [OCC_W-1:0]      buf_cnt;
    logic                  buf_vld;
    logic [WORD_WIDTH-1:0] buf_dat;
    logic                  buf_flush;
    logic                  credit_ok;
    logic                  in_cap;
    logic [CNT_W-1:0]      word_off;
    logic                  grant;
    logic                  rv_dec;
    logic                  fire;
    logic                  clear_hit;

    hsid_fifo #(.W(WORD_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (buf_flush),
        .wr_vld_i (mem_rvalid && (state_q == S_STREAM)),
        .wr_dat_i (mem_rdata),
        .rd_rdy_i (fire),
        .rd_vld_o (buf_vld),
        .rd_dat_o (buf_dat),
        .count_o  (buf_cnt)
    );

    assign busy               = (state_q != S_IDLE);
    assign start              = (state_q == S_START);
    assign clear              = clear_q;
    assign job_done           = done_p_q;
    assign job_error          = err_p_q;
    assign job_cancelled      = canc_p_q;
    assign hsp_bands          = busy ? bands_q : '0;
    assign hsp_library_size   = busy ? size_q : '0;
    assign band_data_in_valid = (state_q == S_STREAM) && buf_vld;
    assign band_data_in       = band_data_in_valid ? buf_dat : '0;
    assign fire               = band_data_in_valid && ready;
    assign clear_hit          = cmd_clear && (state_q != S_IDLE);
    assign buf_flush          = clear_hit || (state_q == S_FLUSH);

    // Words in flight plus words buffered must leave room for one more response.
    assign credit_ok = ({1'b0, out_q} + {1'b0, buf_cnt}) < (OCC_W+1)'(BUF_DEPTH);
    assign mem_req   = (state_q == S_STREAM) && (req_cnt_q < total_q) && credit_ok;
    assign in_cap    = req_cnt_q < CNT_W'(wpp_q);
    assign word_off  = in_cap ? req_cnt_q : req_cnt_q - CNT_W'(wpp_q);
    assign mem_addr  = mem_req ? (in_cap ? cap_q : lib_q) + ADDR_WIDTH'(word_off) * ADDR_WIDTH'(BYTES) : '0;
    assign grant     = mem_req && mem_gnt;
    // A response with nothing outstanding belongs to a request lost to reset.
    assign rv_dec    = mem_rvalid && (out_q != '0);
    assign wpp_calc  = ({1'b0, cmd_hsp_bands} + WPP_W'(1)) >> 1;

    always_comb begin
        state_d    = state_q;
        bands_d    = bands_q;
        size_d     = size_q;
        cap_d      = cap_q;
        lib_d      = lib_q;
        wpp_d      = wpp_q;
        total_d    = total_q;
        req_cnt_d  = grant ? req_cnt_q + CNT_W'(1) : req_cnt_q;
        xfer_cnt_d = fire ? xfer_cnt_q + CNT_W'(1) : xfer_cnt_q;
        out_d      = out_q;
        cancel_d   = cancel_q;
        done_p_d   = 1'b0;
        err_p_d    = 1'b0;
        canc_p_d   = 1'b0;
        clear_d    = 1'b0;
        if (grant && !rv_dec) begin
            out_d = out_q + OCC_W'(1);
        end else if (!grant && rv_dec) begin
            out_d = out_q - OCC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    bands_d = cmd_hsp_bands;
                    size_d  = cmd_library_size;
                    cap_d   = cmd_captured_addr;
                    lib_d   = cmd_library_addr;
                    wpp_d   = wpp_calc;
                    total_d = CNT_W'(wpp_calc) * (CNT_W'(cmd_library_size) + CNT_W'(1));
                    if (cmd_hsp_bands < HSP_BANDS_WIDTH'(7) || cmd_library_size == '0) begin
                        err_p_d = 1'b1;
                    end else begin
                        state_d    = S_START;
                        req_cnt_d  = '0;
                        xfer_cnt_d = '0;
                    end
                end
            end
            S_START: state_d = S_STREAM;
            S_STREAM: begin
                if (error) begin
                    state_d  = S_FLUSH;
                    cancel_d = 1'b0;
                end else if (cancelled) begin
                    state_d  = S_FLUSH;
                    cancel_d = 1'b1;
                end else if (fire && (xfer_cnt_q + CNT_W'(1) == total_q)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    done_p_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (error) begin
                    state_d  = S_FLUSH;
                    cancel_d = 1'b0;
                end else if (cancelled) begin
                    state_d  = S_FLUSH;
                    cancel_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (out_q == '0) begin
                    state_d  = S_IDLE;
                    canc_p_d = cancel_q;
                    err_p_d  = !cancel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Host abort wins over anything the controller reports in the same cycle.
        if (clear_hit) begin
            clear_d  = 1'b1;
            state_d  = S_FLUSH;
            cancel_d = 1'b1;
            done_p_d = 1'b0;
            err_p_d  = 1'b0;
            canc_p_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bands_q    <= '0;
            size_q     <= '0;
            cap_q      <= '0;
            lib_q      <= '0;
            wpp_q      <= '0;
            total_q    <= '0;
            req_cnt_q  <= '0;
            xfer_cnt_q <= '0;
            out_q      <= '0;
            cancel_q   <= 1'b0;
            done_p_q   <= 1'b0;
            err_p_q    <= 1'b0;
            canc_p_q   <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bands_q    <= bands_d;
            size_q     <= size_d;
            cap_q      <= cap_d;
            lib_q      <= lib_d;
            wpp_q      <= wpp_d;
            total_q    <= total_d;
            req_cnt_q  <= req_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            out_q      <= out_d;
            cancel_q   <= cancel_d;
            done_p_q   <= done_p_d;
            err_p_q    <= err_p_d;
            canc_p_q   <= canc_p_d;
            clear_q    <= clear_d;
        end
    end

`ifdef HSID_STREAMER_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && state_d == S_START) begin
            stall_d = '0;
        end else if (band_data_in_valid && !ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hsid_band_streamer.sv
// Self-checking bench for hsid_band_streamer: OBI memory agent, controller stub and a per-pixel reference model.
module tb_hsid_band_streamer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start, cmd_clear;
    logic [31:0] cmd_captured_addr, cmd_library_addr;
    logic [7:0]  cmd_hsp_bands, cmd_library_size;
    logic        busy, job_done, job_error, job_cancelled;
    logic [31:0] stall_cycles;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        start, clear;
    logic [7:0]  hsp_bands, hsp_library_size;
    logic [31:0] band_data_in;
    logic        band_data_in_valid, ready, done, error, cancelled;

    always #5 clk = ~clk;

    hsid_band_streamer dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_clear(cmd_clear),
        .cmd_captured_addr(cmd_captured_addr), .cmd_library_addr(cmd_library_addr),
        .cmd_hsp_bands(cmd_hsp_bands), .cmd_library_size(cmd_library_size),
        .busy(busy), .job_done(job_done), .job_error(job_error), .job_cancelled(job_cancelled),
        .stall_cycles(stall_cycles), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .start(start), .clear(clear),
        .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size), .band_data_in(band_data_in),
        .band_data_in_valid(band_data_in_valid), .ready(ready), .done(done), .error(error),
        .cancelled(cancelled)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // agent configuration and observations
    int  rmode = 0;
    bit  grand = 1'b0;
    int  lat = 1;
    bit  chk_credit = 1'b0;
    int  cyc = 0;
    int  gnt_cnt, rcv_cnt, xfer_cnt, stall_cnt, start_cnt, done_cnt, err_cnt, canc_cnt, clear_cnt;
    int  busy_seen, req_seen, vld_seen, credit_viol, addr_viol;
    int  last_rv_cyc, canc_cyc;
    bit  hold_pending = 1'b0;
    logic [31:0] hold_addr;
    logic [31:0] exp_addr[$], exp_data[$], got_addr[$], got_data[$], pend_dat[$];
    int          pend_due[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Expected word stream: captured pixel, then library pixels 0..size-1, each wpp words long.
    task automatic build_expected(input logic [31:0] cap, input logic [31:0] lib,
                                  input int bands, input int size);
        int wpp;
        logic [31:0] a;
        wpp = (bands + 1) / 2;
        exp_addr.delete();
        exp_data.delete();
        for (int p = 0; p <= size; p++) begin
            for (int w = 0; w < wpp; w++) begin
                if (p == 0) a = cap + 32'(4 * w);
                else        a = lib + 32'(4 * ((p - 1) * wpp + w));
                exp_addr.push_back(a);
                exp_data.push_back(mem_word(a));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_obs();
        gnt_cnt = 0; rcv_cnt = 0; xfer_cnt = 0; stall_cnt = 0; start_cnt = 0; done_cnt = 0;
        err_cnt = 0; canc_cnt = 0; clear_cnt = 0; busy_seen = 0; req_seen = 0; vld_seen = 0;
        credit_viol = 0; addr_viol = 0; last_rv_cyc = -1; canc_cyc = -1;
        got_addr.delete();
        got_data.delete();
    endtask

    // OBI memory, ready generator and output monitor; decides this cycle's inputs 1ns after the edge.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; ready = 1'b0;
        reset_obs();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                mem_rvalid  = 1'b1;
                mem_rdata   = pend_dat.pop_front();
                rcv_cnt++;
                last_rv_cyc = cyc;
            end
            if (chk_credit) begin
                if ((gnt_cnt - xfer_cnt) > 4 || (mem_req && (gnt_cnt - xfer_cnt) >= 4)) credit_viol++;
                if (hold_pending && (!mem_req || mem_addr !== hold_addr)) addr_viol++;
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                mem_gnt = grand ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (mem_gnt) begin
                    pend_due.push_back(cyc + lat);
                    pend_dat.push_back(mem_word(mem_addr));
                    got_addr.push_back(mem_addr);
                    gnt_cnt++;
                end
            end
            hold_pending = mem_req && !mem_gnt;
            hold_addr    = mem_addr;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 3 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (band_data_in_valid && ready) begin
                got_data.push_back(band_data_in);
                xfer_cnt++;
            end
            if (band_data_in_valid && !ready) stall_cnt++;
            if (band_data_in_valid) vld_seen++;
            if (start) start_cnt++;
            if (job_done) done_cnt++;
            if (job_error) err_cnt++;
            if (job_cancelled) begin canc_cnt++; canc_cyc = cyc; end
            if (clear) clear_cnt++;
            if (busy) busy_seen++;
            if (mem_req) req_seen++;
        end
    end

    task automatic launch_job(input logic [31:0] cap, input logic [31:0] lib,
                              input int bands, input int size);
        for (int i = 0; i < 100 && pend_due.size() != 0; i++) step();
        reset_obs();
        build_expected(cap, lib, bands, size);
        cmd_captured_addr = cap;
        cmd_library_addr  = lib;
        cmd_hsp_bands     = 8'(bands);
        cmd_library_size  = 8'(size);
        cmd_start         = 1'b1;
        step();
        cmd_start         = 1'b0;
    endtask

    task automatic wait_xfers(input int n, output bit ok);
        for (int i = 0; i < 3000 && xfer_cnt < n; i++) step();
        ok = (xfer_cnt >= n);
    endtask

    task automatic run_job(input string tag, input logic [31:0] cap, input logic [31:0] lib,
                           input int bands, input int size);
        bit ok;
        int bad;
        int exp_stall;
        launch_job(cap, lib, bands, size);
        chk_credit = 1'b1;
        n_cmp++;
        if (busy !== 1'b1 || hsp_bands !== 8'(bands) || hsp_library_size !== 8'(size)) begin
            n_fail++;
            $display("FAIL %s cfg_hold: busy=%b bands=%0d size=%0d, want busy=1 bands=%0d size=%0d",
                     tag, busy, hsp_bands, hsp_library_size, bands, size);
        end
        wait_xfers(exp_addr.size(), ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s stream_timeout: got %0d words, want %0d", tag, xfer_cnt, exp_addr.size());
        end
        step();
        step();
        n_cmp++;
        if (job_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait_state: job_done=%b busy=%b, want 0/1", tag, job_done, busy);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        n_cmp++;
        if (job_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s job_done_pulse: got %b want 1", tag, job_done);
        end
        step();
        n_cmp++;
        if (job_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s job_end: job_done=%b busy=%b, want 0/0", tag, job_done, busy);
        end
        chk_credit = 1'b0;
        bad = 0;
        foreach (exp_addr[i]) if (i >= got_addr.size() || got_addr[i] !== exp_addr[i]) bad++;
        n_cmp++;
        if (bad != 0 || got_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s addr_seq: %0d wrong of %0d, %0d requested, want %0d",
                     tag, bad, exp_addr.size(), got_addr.size(), exp_addr.size());
        end
        bad = 0;
        foreach (exp_data[i]) if (i >= got_data.size() || got_data[i] !== exp_data[i]) bad++;
        n_cmp++;
        if (bad != 0 || got_data.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL %s data_seq: %0d wrong, %0d words streamed, want %0d",
                     tag, bad, got_data.size(), exp_data.size());
        end
        n_cmp++;
        if (start_cnt != 1 || done_cnt != 1 || err_cnt != 0 || canc_cnt != 0) begin
            n_fail++;
            $display("FAIL %s pulses: start=%0d done=%0d err=%0d canc=%0d, want 1/1/0/0",
                     tag, start_cnt, done_cnt, err_cnt, canc_cnt);
        end
        n_cmp++;
        if (credit_viol != 0 || addr_viol != 0) begin
            n_fail++;
            $display("FAIL %s obi_rules: credit_viol=%0d addr_hold_viol=%0d, want 0/0",
                     tag, credit_viol, addr_viol);
        end
`ifdef HSID_STREAMER_STATS_EN
        exp_stall = stall_cnt;
`else
        exp_stall = 0;
`endif
        n_cmp++;
        if (stall_cycles !== 32'(exp_stall)) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, exp_stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({busy, job_done, job_error, job_cancelled, mem_req, start, clear, band_data_in_valid} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, job_done, job_error, job_cancelled, mem_req, start, clear, band_data_in_valid});
        end
        n_cmp++;
        if ({mem_addr, band_data_in, stall_cycles, hsp_bands, hsp_library_size} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h data=%h stall=%0d bands=%0d size=%0d, want all 0",
                     mem_addr, band_data_in, stall_cycles, hsp_bands, hsp_library_size);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        rmode = 0; grand = 1'b0; lat = 1;
        run_job("basic", 32'h0000_1000, 32'h0000_8000, 8, 2);
        n_cmp++;
        if (got_data.size() != 12) begin
            n_fail++;
            $display("FAIL basic_word_count: got %0d want 12", got_data.size());
        end
    endtask

    task automatic test_config_reject();
        int bands_t[2] = '{6, 8};
        int size_t[2]  = '{2, 0};
        for (int k = 0; k < 2; k++) begin
            reset_obs();
            cmd_captured_addr = $urandom;
            cmd_library_addr  = $urandom;
            cmd_hsp_bands     = 8'(bands_t[k]);
            cmd_library_size  = 8'(size_t[k]);
            cmd_start = 1'b1;
            step();
            cmd_start = 1'b0;
            repeat (5) step();
            n_cmp++;
            if (err_cnt != 1 || start_cnt != 0 || req_seen != 0 || busy_seen != 0) begin
                n_fail++;
                $display("FAIL reject_%0d: job_error=%0d start=%0d mem_req=%0d busy=%0d cycles, want 1/0/0/0",
                         k, err_cnt, start_cnt, req_seen, busy_seen);
            end
        end
    endtask

    task automatic test_odd_bands();
        logic [31:0] lib;
        rmode = 0; grand = 1'b1; lat = 2;
        lib = $urandom & 32'hFFFF_FFFC;
        run_job("odd_bands", 32'hFFFF_FFF4, lib, 9, 3);
        n_cmp++;
        if (got_addr.size() != 20 || got_addr[got_addr.size() - 1] !== lib + 32'(4 * (5 * 3 - 1))) begin
            n_fail++;
            $display("FAIL odd_last_addr: %0d reqs, last=%h, want 20 reqs last=%h", got_addr.size(),
                     (got_addr.size() != 0) ? got_addr[got_addr.size() - 1] : 32'h0, lib + 32'(4 * 14));
        end
    endtask

    task automatic test_backpressure();
        rmode = 1; grand = 1'b1; lat = 3;
        for (int k = 0; k < 2; k++) begin
            run_job("backpressure", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    $urandom_range(7, 16), $urandom_range(1, 3));
        end
    endtask

    task automatic test_random_jobs();
        for (int k = 0; k < 4; k++) begin
            rmode = 2; grand = 1'b1; lat = $urandom_range(1, 4);
            run_job("random", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    $urandom_range(7, 20), $urandom_range(1, 4));
        end
    endtask

    task automatic test_clear();
        bit ok;
        int pending, xfer_at, clr_cyc;
        rmode = 0; grand = 1'b0; lat = 3;
        launch_job(32'h0000_2000, 32'h0001_0000, 16, 3);
        wait_xfers(5, ok);
        pending = pend_due.size();
        xfer_at = xfer_cnt;
        cmd_clear = 1'b1;
        step();
        cmd_clear = 1'b0;
        clr_cyc = cyc;
        n_cmp++;
        if (!ok || pending == 0) begin
            n_fail++;
            $display("FAIL clear_setup: transfers=%0d outstanding=%0d, want >=5 and >0", xfer_cnt, pending);
        end
        n_cmp++;
        if (clear !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0 || band_data_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_pulse: clear=%b busy=%b mem_req=%b valid=%b, want 1/1/0/0",
                     clear, busy, mem_req, band_data_in_valid);
        end
        req_seen = 0;
        vld_seen = 0;
        for (int i = 0; i < 50 && canc_cnt == 0; i++) step();
        step();
        n_cmp++;
        if (canc_cnt != 1 || err_cnt != 0 || done_cnt != 0 || clear_cnt != 1) begin
            n_fail++;
            $display("FAIL clear_status: cancelled=%0d error=%0d done=%0d clear=%0d, want 1/0/0/1",
                     canc_cnt, err_cnt, done_cnt, clear_cnt);
        end
        n_cmp++;
        if (last_rv_cyc < clr_cyc || canc_cyc <= last_rv_cyc || canc_cyc > last_rv_cyc + 3) begin
            n_fail++;
            $display("FAIL clear_cancel_time: cancel at %0d, last rvalid at %0d, clear at %0d",
                     canc_cyc, last_rv_cyc, clr_cyc);
        end
        n_cmp++;
        if (req_seen != 0 || vld_seen != 0 || xfer_cnt != xfer_at || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flush: req=%0d valid=%0d transfers=%0d (want %0d) busy=%b",
                     req_seen, vld_seen, xfer_cnt, xfer_at, busy);
        end
        rmode = 2; grand = 1'b1;
        run_job("after_clear", 32'h0000_3000, 32'h0002_0000, 10, 2);
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        rmode = 0; grand = 1'b0; lat = 4;
        launch_job(32'h0000_4000, 32'h0003_0000, 14, 3);
        wait_xfers(3, ok);
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({busy, mem_req, band_data_in_valid, start, clear} !== 5'h0 || stall_cycles !== 32'h0 ||
            mem_addr !== 32'h0 || hsp_bands !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_mid_job: busy=%b req=%b valid=%b start=%b clear=%b stall=%0d addr=%h, want 0",
                     busy, mem_req, band_data_in_valid, start, clear, stall_cycles, mem_addr);
        end
        step();
        rst_n = 1'b1;
        vld_seen = 0;
        req_seen = 0;
        busy_seen = 0;
        repeat (8) step();
        n_cmp++;
        if (!ok || vld_seen != 0 || req_seen != 0 || busy_seen != 0) begin
            n_fail++;
            $display("FAIL reset_late_rsp: valid=%0d req=%0d busy=%0d cycles after reset, want 0",
                     vld_seen, req_seen, busy_seen);
        end
        run_job("after_reset", 32'h0000_5000, 32'h0004_0000, 7, 1);
    endtask

    task automatic test_ctrl_error();
        bit ok;
        rmode = 1; grand = 1'b1; lat = 3;
        launch_job(32'h0000_6000, 32'h0005_0000, 8, 2);
        wait_xfers(exp_addr.size(), ok);
        step();
        step();
        error = 1'b1;
        step();
        error = 1'b0;
        for (int i = 0; i < 20 && err_cnt == 0; i++) step();
        step();
        n_cmp++;
        if (!ok || err_cnt != 1 || done_cnt != 0 || canc_cnt != 0) begin
            n_fail++;
            $display("FAIL ctrl_error_status: streamed=%0d error=%0d done=%0d cancelled=%0d, want all/1/0/0",
                     xfer_cnt, err_cnt, done_cnt, canc_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_error_busy: got %b want 0", busy);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_clear = 1'b0;
        cmd_captured_addr = '0; cmd_library_addr = '0; cmd_hsp_bands = '0; cmd_library_size = '0;
        done = 1'b0; error = 1'b0; cancelled = 1'b0;
        test_reset();
        test_basic();
        test_config_reject();
        test_odd_bands();
        test_backpressure();
        test_random_jobs();
        test_clear();
        test_reset_mid_job();
        test_ctrl_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hsid_band_streamer.md
Name: hsid_band_streamer

Overview:
- Transmit side of the band-data stream consumed by the HSID main controller.
- On a host command, fetches the captured pixel, then every library reference pixel, from memory over an OBI-style read port.
- Buffers the fetched words and drives them as a `band_data_in` / `band_data_in_valid` stream under the controller's `ready` backpressure.
- Generates the controller's `start` and `clear`, holds its configuration stable, and reports completion, error or cancellation to the host.

Parameters:
- WORD_WIDTH, HSID_WORD_WIDTH: width of the data word; each word carries two packed bands.
- HSP_BANDS_WIDTH, HSID_HSP_BANDS_WIDTH: width of the band count.
- HSP_LIBRARY_WIDTH, HSID_HSP_LIBRARY_WIDTH: width of the library size.
- ADDR_WIDTH, 32: width of the memory byte address.
- BUF_DEPTH, 4: output buffer depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_start  in  1  begin job; sampled in S_IDLE only
- cmd_clear  in  1  abort current job
- cmd_captured_addr  in  ADDR_WIDTH  byte address of captured pixel
- cmd_library_addr  in  ADDR_WIDTH  byte address of library pixel 0
- cmd_hsp_bands  in  HSP_BANDS_WIDTH  bands per pixel
- cmd_library_size  in  HSP_LIBRARY_WIDTH  number of reference pixels
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse on success
- job_error  out  1  one-cycle pulse on rejected configuration or controller error
- job_cancelled  out  1  one-cycle pulse on abort
- stall_cycles  out  32  cycles with valid high and ready low (see optional feature)
- mem_req  out  1  read request
- mem_addr  out  ADDR_WIDTH  word-aligned read address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_WIDTH  read data
- start  out  1  to controller
- clear  out  1  to controller
- hsp_bands  out  HSP_BANDS_WIDTH  to controller, held for the whole job
- hsp_library_size  out  HSP_LIBRARY_WIDTH  to controller, held for the whole job
- band_data_in  out  WORD_WIDTH  stream data
- band_data_in_valid  out  1  stream valid
- ready  in  1  controller accepts a word
- done, error, cancelled  in  1 each  controller status pulses

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - Reset value of every output is 0.
  - Reset clears the state, counters, outstanding count and buffer.
  - Reset mid-job behaves the same: a response arriving after reset is dropped.
- Word count:
  - wpp = (bands + 1) / 2, computed on HSP_BANDS_WIDTH+1 bits.
  - total = wpp * (1 + library_size), on HSP_BANDS_WIDTH+HSP_LIBRARY_WIDTH+1 bits.
- Address sequence:
  - Word i < wpp is at captured_addr + i*(WORD_WIDTH/8).
  - Word i >= wpp is at library_addr + (i - wpp)*(WORD_WIDTH/8).
  - Addresses wrap modulo 2^ADDR_WIDTH.
- States:
  - S_IDLE: on cmd_start, latch the config.
    - If bands < 7 or library_size == 0: pulse job_error, stay in S_IDLE, never assert start.
    - Otherwise go to S_START.
  - S_START: start = 1 for exactly one cycle, then S_STREAM.
  - S_STREAM: issue requests and drain the buffer.
    - When total words have been transferred, go to S_WAIT.
    - On error from the controller, go to S_FLUSH (reason error).
  - S_WAIT: done → pulse job_done, go to S_IDLE. error → S_FLUSH (reason error).
  - S_FLUSH: mem_req = 0; responses are discarded.
    - Once outstanding == 0, pulse job_error or job_cancelled per the stored reason, then go to S_IDLE.
- Request issue:
  - mem_req = 1 only when all three hold: in S_STREAM, words still to request, and outstanding + buffer count < BUF_DEPTH.
  - mem_addr is held stable while mem_req = 1 and mem_gnt = 0.
  - The request counter advances on mem_req && mem_gnt.
- Responses:
  - On mem_rvalid, the word is written into the buffer.
  - The buffer never overflows because of the credit rule above.
  - A word written on cycle N may appear on band_data_in at cycle N+1 at the earliest.
- Stream handshake:
  - band_data_in_valid = buffer not empty in S_STREAM.
  - A transfer occurs on valid && ready; band_data_in holds stable until then.
  - Simultaneous buffer write and read in one cycle is supported.
- Outstanding count:
  - +1 on a grant, -1 on rvalid; both in the same cycle leaves it unchanged.
- Clear:
  - cmd_clear outside S_IDLE drives clear = 1 for one cycle and goes to S_FLUSH (reason cancel).
  - The buffer is emptied immediately.
  - cmd_clear in S_IDLE is ignored. cmd_clear takes priority over a simultaneous done or error.
- Status outputs:
  - busy = state != S_IDLE.
  - hsp_bands and hsp_library_size are driven from the latched config while busy, 0 otherwise.
  - cmd_start while busy is ignored.

Optional Feature:
- Macro: HSID_STREAMER_STATS_EN.
- Defined: stall_cycles is a saturating 32-bit counter.
  - Increments each cycle with band_data_in_valid && !ready.
  - Clears when a job starts (S_IDLE → S_START).
  - Holds its value after the job ends.
- Undefined: stall_cycles tied to 0 and no counter logic.

Test Plan:
- Basic job: bands = 8, size = 2, ready always 1, zero-wait memory → 12 words, captured words first, then library words; band_data_in matches memory in order; start pulses once; job_done one cycle after done.
- Config rejection: bands = 6 → job_error pulse, start, mem_req and busy stay 0. Separately, size = 0 → same result.
- Odd band count: bands = 9 → wpp = 5, total 5*(1+size) words; the last library address is library_addr + 4*(5*size - 1) for a 32-bit word.
- Backpressure: ready toggles 1,0,0,1,…; gnt has random waits; rvalid has 3-cycle latency → outstanding + count never exceeds 4; no word lost or duplicated; stall_cycles equals the number of valid & !ready cycles when HSID_STREAMER_STATS_EN is defined, else 0.
- Clear mid-stream: cmd_clear after 5 transfers with 2 outstanding → clear pulse, mem_req drops, the 2 late responses are discarded, job_cancelled fires after the last rvalid, and a new job then runs cleanly.
- Controller error in S_WAIT: error pulse → job_error, busy drops once outstanding == 0.
